// File: rtl/stream_minmax_tracker.sv
// Frame min/max tracker: running min/max (first-occurrence index) and element count over a val/rdy input stream.
// Latency: out_val rises the cycle after the in_last transfer; the result is held in registers until it is taken.
// Backpressure: in_rdy is low while a result is pending; the result is held stable until out_rdy.
module stream_minmax_tracker #(
   parameter int p_nbits     = 8,
   parameter int p_cnt_nbits = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [p_nbits-1:0]     in_data,
   input  logic                   in_last,
   input  logic                   signed_mode,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [p_nbits-1:0]     out_min,
   output logic [p_nbits-1:0]     out_max,
   output logic [p_cnt_nbits-1:0] out_min_idx,
   output logic [p_cnt_nbits-1:0] out_max_idx,
   output logic [p_cnt_nbits-1:0] out_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [p_cnt_nbits-1:0] CNT_ONE = {{(p_cnt_nbits-1){1'b0}}, 1'b1};
   localparam logic [p_cnt_nbits-1:0] CNT_MAX = {p_cnt_nbits{1'b1}};

   state_t                 state_q, state_d;
   logic [p_nbits-1:0]     min_q, min_d;
   logic [p_nbits-1:0]     max_q, max_d;
   logic [p_cnt_nbits-1:0] min_idx_q, min_idx_d;
   logic [p_cnt_nbits-1:0] max_idx_q, max_idx_d;
   logic [p_cnt_nbits-1:0] count_q, count_d;
   logic                   mode_q, mode_d;

   logic in_xfer;
   logic out_xfer;
   logic new_lt_min;
   logic new_gt_max;

   // Handshakes depend on state only; reset also holds in_rdy low so nothing is taken during reset.
   assign in_rdy   = !reset && (state_q != ST_DONE);
   assign out_val  = (state_q == ST_DONE);
   assign in_xfer  = in_val && in_rdy;
   assign out_xfer = out_val && out_rdy;

   // Strict compares under the mode latched on the frame's first element.
   always_comb begin
      new_lt_min = 1'b0;
      new_gt_max = 1'b0;
      if (mode_q) begin
         new_lt_min = $signed(in_data) < $signed(min_q);
         new_gt_max = $signed(in_data) > $signed(max_q);
      end else begin
         new_lt_min = in_data < min_q;
         new_gt_max = in_data > max_q;
      end
   end

   // Next-state and result update. count_q doubles as the position of the incoming
   // element, so a saturated count also yields the saturated index.
   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      max_d     = max_q;
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;
      count_d   = count_q;
      mode_d    = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (in_xfer) begin
               min_d     = in_data;
               max_d     = in_data;
               min_idx_d = '0;
               max_idx_d = '0;
               count_d   = CNT_ONE;
               mode_d    = signed_mode;
               state_d   = in_last ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (in_xfer) begin
               if (new_lt_min) begin
                  min_d     = in_data;
                  min_idx_d = count_q;
               end
               if (new_gt_max) begin
                  max_d     = in_data;
                  max_idx_d = count_q;
               end
               if (count_q != CNT_MAX) begin
                  count_d = count_q + CNT_ONE;
               end
               if (in_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_xfer) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         count_q   <= '0;
         mode_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         max_q     <= max_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
         count_q   <= count_d;
         mode_q    <= mode_d;
      end
   end

   assign out_min     = min_q;
   assign out_max     = max_q;
   assign out_min_idx = min_idx_q;
   assign out_max_idx = max_idx_q;
   assign out_count   = count_q;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Bench for stream_minmax_tracker: frame-level reference model checked every cycle,
// plus directed frames with hand-computed results.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_stream_minmax_tracker;

   logic       clk;
   logic       reset;
   logic       in_val;
   logic       in_rdy;
   logic [7:0] in_data;
   logic       in_last;
   logic       signed_mode;
   logic       out_val;
   logic       out_rdy;
   logic [7:0] out_min;
   logic [7:0] out_max;
   logic [7:0] out_min_idx;
   logic [7:0] out_max_idx;
   logic [7:0] out_count;

   int n_assert = 0;
   int n_fail   = 0;

   stream_minmax_tracker #(.p_nbits(8), .p_cnt_nbits(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_val      (in_val),
      .in_rdy      (in_rdy),
      .in_data     (in_data),
      .in_last     (in_last),
      .signed_mode (signed_mode),
      .out_val     (out_val),
      .out_rdy     (out_rdy),
      .out_min     (out_min),
      .out_max     (out_max),
      .out_min_idx (out_min_idx),
      .out_max_idx (out_max_idx),
      .out_count   (out_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   logic [7:0] m_elems[$];
   logic       m_mode;
   bit         m_pending = 0;
   bit         m_started = 0;
   logic [7:0] e_min, e_max, e_min_idx, e_max_idx, e_count;

   function automatic int as_num(input logic [7:0] v, input logic sgn);
      if (sgn) return int'($signed(v));
      return int'(v);
   endfunction

   task automatic model_finish_frame();
      int mn, mx, n;
      n  = m_elems.size();
      mn = 0;
      mx = 0;
      for (int i = 0; i < n; i++) begin
         int v;
         v = as_num(m_elems[i], m_mode);
         if (i == 0 || v < as_num(m_elems[mn], m_mode)) mn = i;
         if (i == 0 || v > as_num(m_elems[mx], m_mode)) mx = i;
      end
      e_min     = m_elems[mn];
      e_max     = m_elems[mx];
      e_min_idx = (mn > 255) ? 8'd255 : 8'(mn);
      e_max_idx = (mx > 255) ? 8'd255 : 8'(mx);
      e_count   = (n > 255) ? 8'd255 : 8'(n);
      m_elems.delete();
      m_pending = 1;
   endtask

   always @(posedge clk) begin
      m_started = 1;
      if (reset) begin
         m_pending = 0;
         m_elems.delete();
      end else if (m_pending) begin
         if (out_rdy) m_pending = 0;
      end else if (in_val) begin
         if (m_elems.size() == 0) m_mode = signed_mode;
         m_elems.push_back(in_data);
         if (in_last) model_finish_frame();
      end
   end

   // Compare process: handshakes every cycle, result fields whenever a result is due.
   always @(negedge clk) begin
      if (m_started) begin
         chk("in_rdy", 32'(in_rdy), 32'((!reset && !m_pending) ? 1 : 0));
         chk("out_val", 32'(out_val), 32'(m_pending));
         if (m_pending) begin
            chk("model_min", 32'(out_min), 32'(e_min));
            chk("model_max", 32'(out_max), 32'(e_max));
            chk("model_min_idx", 32'(out_min_idx), 32'(e_min_idx));
            chk("model_max_idx", 32'(out_max_idx), 32'(e_max_idx));
            chk("model_count", 32'(out_count), 32'(e_count));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] fq[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one element and hold it until it is accepted (bounded).
   task automatic push(input logic [7:0] d, input logic last, input logic mode);
      bit ok;
      in_val      = 1'b1;
      in_data     = d;
      in_last     = last;
      signed_mode = mode;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         ok = in_rdy;
         step();
         if (ok) return;
      end
      n_assert++;
      n_fail++;
      $display("FAIL push_timeout: element %0h never accepted", d);
   endtask

   // Send fq as one frame; mode m0 on the first element, m_rest afterwards.
   task automatic send_fq(input logic m0, input logic m_rest, input bit bubbles);
      for (int i = 0; i < fq.size(); i++) begin
         push(fq[i], (i == fq.size() - 1), (i == 0) ? m0 : m_rest);
         if (bubbles && i != fq.size() - 1) begin
            in_val  = 1'b0;
            in_data = 8'hEE;
            in_last = 1'b1;
            repeat (2) step();
         end
      end
      in_val  = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic expect_res(input string name, input logic [7:0] mn, input logic [7:0] mx,
                             input logic [7:0] mni, input logic [7:0] mxi, input logic [7:0] cnt);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_val === 1'b1) begin
            chk({name, "_min"}, 32'(out_min), 32'(mn));
            chk({name, "_max"}, 32'(out_max), 32'(mx));
            chk({name, "_min_idx"}, 32'(out_min_idx), 32'(mni));
            chk({name, "_max_idx"}, 32'(out_max_idx), 32'(mxi));
            chk({name, "_count"}, 32'(out_count), 32'(cnt));
            step();
            return;
         end
      end
      n_assert++;
      n_fail++;
      $display("FAIL %s_timeout: out_val never rose", name);
   endtask

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset       = 1'b1;
      in_val      = 1'b0;
      in_data     = 8'h00;
      in_last     = 1'b0;
      signed_mode = 1'b0;
      out_rdy     = 1'b1;
      repeat (2) step();
      reset = 1'b0;

      // Reset state over three idle cycles.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_out_val", 32'(out_val), 32'd0);
         chk("rst_in_rdy", 32'(in_rdy), 32'd1);
         chk("rst_data", {out_min, out_max, out_min_idx, out_max_idx}, 32'd0);
         chk("rst_count", 32'(out_count), 32'd0);
         step();
      end

      // Unsigned frame with repeated extremes: ties keep the first index.
      fq = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd1};
      send_fq(1'b0, 1'b0, 1'b0);
      expect_res("unsigned", 8'd1, 8'd9, 8'd2, 8'd1, 8'd5);
      @(negedge clk);
      chk("out_val_drops", 32'(out_val), 32'd0);
      step();

      // Same frame with bubbles.
      send_fq(1'b0, 1'b0, 1'b1);
      expect_res("bubbles", 8'd1, 8'd9, 8'd2, 8'd1, 8'd5);

      // Signed vs unsigned interpretation of 0x7F, 0x80, 0x00.
      fq = '{8'h7F, 8'h80, 8'h00};
      send_fq(1'b1, 1'b1, 1'b0);
      expect_res("signed", 8'h80, 8'h7F, 8'd1, 8'd0, 8'd3);
      send_fq(1'b0, 1'b0, 1'b0);
      expect_res("unsig7f", 8'h00, 8'h80, 8'd2, 8'd1, 8'd3);
      send_fq(1'b1, 1'b0, 1'b0);
      expect_res("tog_signed", 8'h80, 8'h7F, 8'd1, 8'd0, 8'd3);
      send_fq(1'b0, 1'b1, 1'b1);
      expect_res("tog_unsig", 8'h00, 8'h80, 8'd2, 8'd1, 8'd3);

      // Single-element frame.
      fq = '{8'h55};
      send_fq(1'b0, 1'b0, 1'b0);
      expect_res("single", 8'h55, 8'h55, 8'd0, 8'd0, 8'd1);

      // Backpressure: result held for 4 cycles, pending element not consumed.
      out_rdy = 1'b0;
      fq = '{8'd20, 8'd10, 8'd30};
      send_fq(1'b0, 1'b0, 1'b0);
      in_val      = 1'b1;
      in_data     = 8'h11;
      in_last     = 1'b1;
      signed_mode = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_out_val", 32'(out_val), 32'd1);
         chk("bp_in_rdy", 32'(in_rdy), 32'd0);
         chk("bp_minmax", {16'd0, out_min, out_max}, {16'd0, 8'd10, 8'd30});
         chk("bp_idx_cnt", {8'd0, out_min_idx, out_max_idx, out_count}, {8'd0, 8'd1, 8'd2, 8'd3});
         step();
      end
      out_rdy = 1'b1;
      push(8'h11, 1'b1, 1'b0);
      in_val = 1'b0;
      expect_res("after_bp", 8'h11, 8'h11, 8'd0, 8'd0, 8'd1);

      // Reset in mid-frame discards the partial frame.
      push(8'd5, 1'b0, 1'b0);
      push(8'd2, 1'b0, 1'b0);
      in_val = 1'b0;
      reset  = 1'b1;
      step();
      reset = 1'b0;
      push(8'd4, 1'b1, 1'b0);
      in_val = 1'b0;
      expect_res("post_reset", 8'd4, 8'd4, 8'd0, 8'd0, 8'd1);

      // Saturation: 300 elements, new extremes past index 255 record index 255.
      fq.delete();
      for (int i = 0; i < 300; i++) begin
         if (i == 280)      fq.push_back(8'd5);
         else if (i == 290) fq.push_back(8'd200);
         else               fq.push_back(8'd100);
      end
      send_fq(1'b0, 1'b0, 1'b0);
      expect_res("saturate", 8'd5, 8'd200, 8'd255, 8'd255, 8'd255);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
